matrix_mem_arbiter: RTL and testbench

Shares the single matrix register-file port among several coprocessor engines: the host loader, the matrix multiplier and the matrix adder. Each engine keeps its existing register-file port signals (address, type, matrix, read_en, write_en, data) and connects to one requester slot. The arbiter grants the memory port to one slot at a time, returns read data with a one-cycle `data_ready` pulse, and posts single-cycle write pulses into a one-deep buffer per requester. It sits between the engines and the register file; engines need no changes.

---
 rtl/matrix_mem_arbiter_if.sv | 45 ++++
 rtl/matrix_mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_matrix_mem_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_mem_arbiter_if.sv
// matrix_mem_arbiter_if: requester-side and memory-side buses of the matrix
// register-file arbiter. The arbiter uses the slave modport.
interface matrix_mem_arbiter_if #(
  parameter int address_width = 4,
  parameter int width         = 32,
  parameter int n_req         = 3
);
  logic [n_req*address_width-1:0] in_req_address;
  logic [2*n_req-1:0]             in_req_type;
  logic [2*n_req-1:0]             in_req_matrix;
  logic [n_req-1:0]               in_req_read_en;
  logic [n_req-1:0]               in_req_write_en;
  logic [n_req*width-1:0]         in_req_data;

  logic [width-1:0]               out_data;
  logic [n_req-1:0]               out_data_ready;
  logic [n_req-1:0]               out_wbuf_full;
  logic [n_req-1:0]               out_grant;
  logic                           out_error;

  logic [address_width-1:0]       out_mem_address;
  logic [1:0]                     out_mem_type;
  logic [1:0]                     out_mem_matrix;
  logic                           out_mem_read_en;
  logic                           out_mem_write_en;
  logic [width-1:0]               out_mem_data;
  logic [width-1:0]               in_mem_data;
  logic                           in_mem_data_ready;

  modport slave (
    input  in_req_address, in_req_type, in_req_matrix, in_req_read_en,
           in_req_write_en, in_req_data, in_mem_data, in_mem_data_ready,
    output out_data, out_data_ready, out_wbuf_full, out_grant, out_error,
           out_mem_address, out_mem_type, out_mem_matrix, out_mem_read_en,
           out_mem_write_en, out_mem_data
  );

  modport master (
    output in_req_address, in_req_type, in_req_matrix, in_req_read_en,
           in_req_write_en, in_req_data, in_mem_data, in_mem_data_ready,
    input  out_data, out_data_ready, out_wbuf_full, out_grant, out_error,
           out_mem_address, out_mem_type, out_mem_matrix, out_mem_read_en,
           out_mem_write_en, out_mem_data
  );
endinterface

// File: rtl/matrix_mem_arbiter.sv
// matrix_mem_arbiter: shares one matrix register-file port among n_req engines with a
// one-deep posted write buffer per slot. Define MATRIX_ARB_FIXED_PRIO_EN for fixed priority.
module matrix_mem_arbiter #(
  parameter int size          = 4,
  parameter int cell_width    = 8,
  parameter int address_width = 4,
  parameter int width         = cell_width * size,
  parameter int n_req         = 3
) (
  input logic                 in_clk,
  input logic                 in_reset,
  matrix_mem_arbiter_if.slave bus
);
  localparam int PTR_W = (n_req > 1) ? $clog2(n_req) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RESP} state_t;

  state_t                   state;
  logic [PTR_W-1:0]         cur, ptr, win;
  logic                     win_found;
  logic [n_req-1:0]         valid, pend, clr, load;
  logic [n_req-1:0]         grant, data_ready;
  logic                     err;
  logic [width-1:0]         rdata;
  logic [address_width-1:0] mem_address;
  logic [1:0]               mem_type, mem_matrix;
  logic                     mem_read_en, mem_write_en;
  logic [width-1:0]         mem_data;

  logic [address_width-1:0] wb_address [n_req];
  logic [1:0]               wb_type    [n_req];
  logic [1:0]               wb_matrix  [n_req];
  logic [width-1:0]         wb_data    [n_req];

  function automatic logic [n_req-1:0] onehot(input logic [PTR_W-1:0] s);
    return n_req'(1'b1) << s;
  endfunction

  function automatic logic [PTR_W-1:0] slot_after(input logic [PTR_W-1:0] s);
    return PTR_W'((int'(s) + 1) % n_req);
  endfunction

  function automatic int rr_slot(input logic [PTR_W-1:0] base, input int k);
    return (int'(base) + k) % n_req;
  endfunction

  assign clr  = (state == S_WRITE) ? onehot(cur) : '0;
  assign load = bus.in_req_write_en & (~valid | clr);

  // A slot pulsing a write this cycle holds back its read so the write reaches memory first.
  always_comb begin
    pend = '0;
    for (int i = 0; i < n_req; i++) begin
      pend[i] = valid[i] | (bus.in_req_read_en[i] & ~bus.in_req_write_en[i] &
                            ~(state == S_RESP && cur == PTR_W'(i)));
    end
  end

  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int k = 0; k < n_req; k++) begin
`ifdef MATRIX_ARB_FIXED_PRIO_EN
      if (!win_found && pend[k]) begin
        win_found = 1'b1;
        win       = PTR_W'(k);
      end
`else
      if (!win_found && pend[rr_slot(ptr, k)]) begin
        win_found = 1'b1;
        win       = PTR_W'(rr_slot(ptr, k));
      end
`endif
    end
  end

  always_ff @(posedge in_clk) begin
    for (int i = 0; i < n_req; i++) begin
      if (load[i]) begin
        wb_address[i] <= bus.in_req_address[i*address_width +: address_width];
        wb_type[i]    <= bus.in_req_type[2*i +: 2];
        wb_matrix[i]  <= bus.in_req_matrix[2*i +: 2];
        wb_data[i]    <= bus.in_req_data[i*width +: width];
      end
    end
  end

  always_ff @(posedge in_clk) begin
    if (!in_reset) begin
      state        <= S_IDLE;
      cur          <= '0;
      ptr          <= '0;
      valid        <= '0;
      err          <= 1'b0;
      grant        <= '0;
      data_ready   <= '0;
      rdata        <= '0;
      mem_address  <= '0;
      mem_type     <= '0;
      mem_matrix   <= '0;
      mem_read_en  <= 1'b0;
      mem_write_en <= 1'b0;
      mem_data     <= '0;
    end else begin
      valid <= (valid & ~clr) | load;
      if (|(bus.in_req_write_en & valid & ~clr)) err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (win_found) begin
            cur   <= win;
            grant <= onehot(win);
            if (valid[win]) begin
              mem_address  <= wb_address[win];
              mem_type     <= wb_type[win];
              mem_matrix   <= wb_matrix[win];
              mem_data     <= wb_data[win];
              mem_write_en <= 1'b1;
              state        <= S_WRITE;
            end else begin
              mem_address <= bus.in_req_address[int'(win)*address_width +: address_width];
              mem_type    <= bus.in_req_type[int'(win)*2 +: 2];
              mem_matrix  <= bus.in_req_matrix[int'(win)*2 +: 2];
              mem_read_en <= 1'b1;
              state       <= S_READ;
            end
          end
        end
        S_WRITE: begin
          mem_write_en <= 1'b0;
          grant        <= '0;
          ptr          <= slot_after(cur);
          state        <= S_IDLE;
        end
        S_READ: begin
          if (bus.in_mem_data_ready) begin
            rdata       <= bus.in_mem_data;
            data_ready  <= onehot(cur);
            mem_read_en <= 1'b0;
            state       <= S_RESP;
          end
        end
        S_RESP: begin
          data_ready <= '0;
          grant      <= '0;
          rdata      <= '0;
          ptr        <= slot_after(cur);
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.out_data         = rdata;
  assign bus.out_data_ready   = data_ready;
  assign bus.out_wbuf_full    = valid;
  assign bus.out_grant        = grant;
  assign bus.out_error        = err;
  assign bus.out_mem_address  = mem_address;
  assign bus.out_mem_type     = mem_type;
  assign bus.out_mem_matrix   = mem_matrix;
  assign bus.out_mem_read_en  = mem_read_en;
  assign bus.out_mem_write_en = mem_write_en;
  assign bus.out_mem_data     = mem_data;
endmodule

// File: tb/tb_matrix_mem_arbiter.sv
// tb_matrix_mem_arbiter: directed self-checking bench for matrix_mem_arbiter with a
// stall-programmable memory model and a monitor recording memory-side activity.
module tb_matrix_mem_arbiter;
  localparam int AW = 4;
  localparam int W  = 32;
  localparam int N  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_mem_arbiter_if #(.address_width(AW), .width(W), .n_req(N)) bus ();

  matrix_mem_arbiter #(.size(4), .cell_width(8), .address_width(AW), .n_req(N)) dut (
    .in_clk   (clk),
    .in_reset (rst_n),
    .bus      (bus)
  );

  int tests = 0;
  int fails = 0;

  // Memory model: answers once read_en has been high for more than `stall` sampled edges.
  int          stall = 0;
  logic [W-1:0] mem_rdata = '0;
  int          rd_cycles = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          dr_cnt = 0;
  int          wr_cyc = 0;
  int          rd_start_cyc = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [AW-1:0] rd_addr = '0;
  logic [1:0]  wr_matrix = '0;
  logic [W-1:0] wr_data = '0;

  assign bus.in_mem_data       = mem_rdata;
  assign bus.in_mem_data_ready = bus.out_mem_read_en && (rd_cycles >= stall);

  always @(posedge clk) begin
    cyc       <= cyc + 1;
    rd_cycles <= bus.out_mem_read_en ? rd_cycles + 1 : 0;
    if (bus.out_mem_read_en && rd_cycles == 0) begin
      rd_start_cyc <= cyc;
      rd_addr      <= bus.out_mem_address;
    end
    if (bus.out_mem_write_en) begin
      wr_cnt    <= wr_cnt + 1;
      wr_cyc    <= cyc;
      wr_addr   <= bus.out_mem_address;
      wr_matrix <= bus.out_mem_matrix;
      wr_data   <= bus.out_mem_data;
    end
    if (|bus.out_data_ready) dr_cnt <= dr_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int s, input logic [AW-1:0] a, input logic [1:0] t,
                          input logic [1:0] m, input logic [W-1:0] d);
    bus.in_req_address[s*AW +: AW] = a;
    bus.in_req_type[2*s +: 2]      = t;
    bus.in_req_matrix[2*s +: 2]    = m;
    bus.in_req_data[s*W +: W]      = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests++;
    if ({bus.out_grant, bus.out_data_ready, bus.out_wbuf_full, bus.out_error,
         bus.out_mem_read_en, bus.out_mem_write_en} !== 12'h000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b want 0", {bus.out_grant, bus.out_data_ready,
               bus.out_wbuf_full, bus.out_error, bus.out_mem_read_en, bus.out_mem_write_en});
    end
    tests++;
    if ({bus.out_data, bus.out_mem_data, bus.out_mem_address, bus.out_mem_type,
         bus.out_mem_matrix} !== '0) begin
      fails++;
      $display("FAIL reset_data: out_data=%h mem_data=%h addr=%h want 0",
               bus.out_data, bus.out_mem_data, bus.out_mem_address);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    stall     = 0;
    mem_rdata = 32'hA1B2C3D4;
    set_slot(1, 4'd5, 2'b01, 2'b00, '0);
    bus.in_req_read_en[1] = 1'b1;
    tick();
    tests++;
    if ({bus.out_grant, bus.out_mem_read_en, bus.out_mem_address, bus.out_mem_type,
         bus.out_mem_matrix} !== {3'b010, 1'b1, 4'd5, 2'b01, 2'b00}) begin
      fails++;
      $display("FAIL read_issue: grant=%b ren=%b addr=%0d type=%b mat=%b want 010 1 5 01 00",
               bus.out_grant, bus.out_mem_read_en, bus.out_mem_address, bus.out_mem_type,
               bus.out_mem_matrix);
    end
    tick();
    tests++;
    if ({bus.out_mem_read_en, bus.out_data_ready, bus.out_data} !== {1'b0, 3'b010, 32'hA1B2C3D4}) begin
      fails++;
      $display("FAIL read_resp: ren=%b dr=%b data=%h want 0 010 a1b2c3d4",
               bus.out_mem_read_en, bus.out_data_ready, bus.out_data);
    end
    bus.in_req_read_en[1] = 1'b0;
    tick();
    tests++;
    if ({bus.out_data_ready, bus.out_grant, bus.out_data} !== '0) begin
      fails++;
      $display("FAIL read_done: dr=%b grant=%b data=%h want 0",
               bus.out_data_ready, bus.out_grant, bus.out_data);
    end
  endtask

  task automatic test_reset_mid_read();
    int snap;
    stall     = 50;
    mem_rdata = 32'h0BAD0BAD;
    set_slot(1, 4'd2, 2'b00, 2'b01, '0);
    bus.in_req_read_en[1] = 1'b1;
    tick();
    tick();
    tests++;
    if (bus.out_mem_read_en !== 1'b1) begin
      fails++;
      $display("FAIL midrd_stalled: ren=%b want 1", bus.out_mem_read_en);
    end
    snap  = dr_cnt;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.in_req_read_en[1] = 1'b0;
    tests++;
    if ({bus.out_grant, bus.out_data_ready, bus.out_mem_read_en, bus.out_mem_address,
         bus.out_mem_matrix, bus.out_data} !== '0) begin
      fails++;
      $display("FAIL midrd_reset: grant=%b dr=%b ren=%b addr=%0d data=%h want 0",
               bus.out_grant, bus.out_data_ready, bus.out_mem_read_en,
               bus.out_mem_address, bus.out_data);
    end
    tick();
    tick();
    tick();
    tests++;
    if (dr_cnt !== snap) begin
      fails++;
      $display("FAIL midrd_no_pulse: data_ready pulses=%0d want 0", dr_cnt - snap);
    end
    stall     = 0;
    mem_rdata = 32'h5555AAAA;
    bus.in_req_read_en[1] = 1'b1;
    tick();
    tick();
    tests++;
    if ({bus.out_data_ready, bus.out_data} !== {3'b010, 32'h5555AAAA}) begin
      fails++;
      $display("FAIL midrd_retry: dr=%b data=%h want 010 5555aaaa",
               bus.out_data_ready, bus.out_data);
    end
    bus.in_req_read_en[1] = 1'b0;
    tick();
  endtask

  task automatic test_contention();
    int n;
    int serves0;
    int s;
    int got_slot [4];
    int got_t    [4];
`ifdef MATRIX_ARB_FIXED_PRIO_EN
    int exp_slot [4] = '{0, 0, 1, 2};
`else
    int exp_slot [4] = '{0, 1, 2, 0};
`endif
    rst_n = 1'b0;
    tick();
    rst_n     = 1'b1;
    stall     = 0;
    mem_rdata = 32'h00C0FFEE;
    n         = 0;
    serves0   = 0;
    for (int i = 0; i < 4; i++) begin
      got_slot[i] = -1;
      got_t[i]    = -1;
    end
    set_slot(0, 4'd1, 2'b00, 2'b00, '0);
    set_slot(1, 4'd2, 2'b01, 2'b01, '0);
    set_slot(2, 4'd3, 2'b10, 2'b10, '0);
    bus.in_req_read_en = 3'b111;
    for (int t = 1; t <= 30 && n < 4; t++) begin
      tick();
      if (bus.out_data_ready != 3'b000) begin
        s = (bus.out_data_ready == 3'b001) ? 0 : (bus.out_data_ready == 3'b010) ? 1 :
            (bus.out_data_ready == 3'b100) ? 2 : -1;
        got_slot[n] = s;
        got_t[n]    = t;
        n++;
        if (s == 0) begin
          serves0++;
          if (serves0 == 2) bus.in_req_read_en[0] = 1'b0;
        end else if (s > 0) begin
          bus.in_req_read_en[s] = 1'b0;
        end
      end
    end
    bus.in_req_read_en = 3'b000;
    tests++;
    if (n !== 4) begin
      fails++;
      $display("FAIL cont_count: responses=%0d want 4", n);
    end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (got_slot[i] !== exp_slot[i] || got_t[i] !== 2 + 3*i) begin
        fails++;
        $display("FAIL cont_order[%0d]: slot=%0d at cycle %0d want slot %0d at cycle %0d",
                 i, got_slot[i], got_t[i], exp_slot[i], 2 + 3*i);
      end
    end
    tick();
  endtask

  task automatic test_write_posting();
    int snap;
    snap = wr_cnt;
    set_slot(1, 4'd7, 2'b00, 2'b10, 32'h11);
    bus.in_req_write_en[1] = 1'b1;
    tick();
    bus.in_req_write_en[1] = 1'b0;
    tests++;
    if ({bus.out_wbuf_full, bus.out_mem_write_en} !== {3'b010, 1'b0}) begin
      fails++;
      $display("FAIL wpost_buffered: full=%b wen=%b want 010 0",
               bus.out_wbuf_full, bus.out_mem_write_en);
    end
    tick();
    tests++;
    if ({bus.out_mem_write_en, bus.out_grant, bus.out_mem_address, bus.out_mem_matrix,
         bus.out_mem_data} !== {1'b1, 3'b010, 4'd7, 2'b10, 32'h11}) begin
      fails++;
      $display("FAIL wpost_issue: wen=%b grant=%b addr=%0d mat=%b data=%h want 1 010 7 10 11",
               bus.out_mem_write_en, bus.out_grant, bus.out_mem_address,
               bus.out_mem_matrix, bus.out_mem_data);
    end
    tick();
    tests++;
    if ({bus.out_mem_write_en, bus.out_wbuf_full, bus.out_grant} !== 7'b0) begin
      fails++;
      $display("FAIL wpost_clear: wen=%b full=%b grant=%b want 0",
               bus.out_mem_write_en, bus.out_wbuf_full, bus.out_grant);
    end
    tests++;
    if (wr_cnt - snap !== 1) begin
      fails++;
      $display("FAIL wpost_count: memory writes=%0d want 1", wr_cnt - snap);
    end
  endtask

  task automatic test_overflow();
    int snap;
    bit seen;
    snap      = wr_cnt;
    stall     = 5;
    mem_rdata = 32'hFEEDBEEF;
    set_slot(2, 4'd9, 2'b00, 2'b00, '0);
    bus.in_req_read_en[2] = 1'b1;
    tick();
    set_slot(1, 4'd4, 2'b00, 2'b01, 32'h22);
    bus.in_req_write_en[1] = 1'b1;
    tick();
    bus.in_req_write_en[1] = 1'b0;
    tests++;
    if ({bus.out_wbuf_full, bus.out_error} !== {3'b010, 1'b0}) begin
      fails++;
      $display("FAIL ovf_first: full=%b err=%b want 010 0", bus.out_wbuf_full, bus.out_error);
    end
    tick();
    set_slot(1, 4'd6, 2'b00, 2'b01, 32'h33);
    bus.in_req_write_en[1] = 1'b1;
    tick();
    bus.in_req_write_en[1] = 1'b0;
    tests++;
    if ({bus.out_error, bus.out_mem_read_en} !== 2'b11) begin
      fails++;
      $display("FAIL ovf_error: err=%b ren=%b want 1 1", bus.out_error, bus.out_mem_read_en);
    end
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      tick();
      if (bus.out_data_ready[2]) begin
        seen = 1'b1;
        bus.in_req_read_en[2] = 1'b0;
      end
    end
    bus.in_req_read_en[2] = 1'b0;
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL ovf_read_timeout: slot 2 data_ready=0 want 1");
    end
    for (int t = 0; t < 6; t++) tick();
    tests++;
    if (wr_cnt - snap !== 1 || wr_addr !== 4'd4 || wr_data !== 32'h22 || wr_matrix !== 2'b01) begin
      fails++;
      $display("FAIL ovf_write: writes=%0d addr=%0d data=%h mat=%b want 1 4 22 01",
               wr_cnt - snap, wr_addr, wr_data, wr_matrix);
    end
    tests++;
    if ({bus.out_error, bus.out_wbuf_full} !== {1'b1, 3'b000}) begin
      fails++;
      $display("FAIL ovf_sticky: err=%b full=%b want 1 000", bus.out_error, bus.out_wbuf_full);
    end
    stall = 0;
  endtask

  task automatic test_raw_order();
    int snap;
    int cyc0;
    bit seen;
    snap      = wr_cnt;
    cyc0      = cyc;
    stall     = 0;
    mem_rdata = 32'h44;
    set_slot(1, 4'd3, 2'b00, 2'b00, 32'h44);
    bus.in_req_write_en[1] = 1'b1;
    bus.in_req_read_en[1]  = 1'b1;
    tick();
    bus.in_req_write_en[1] = 1'b0;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      tick();
      if (bus.out_data_ready[1]) begin
        seen = 1'b1;
        bus.in_req_read_en[1] = 1'b0;
      end
    end
    bus.in_req_read_en[1] = 1'b0;
    tests++;
    if (!seen || wr_cnt - snap !== 1) begin
      fails++;
      $display("FAIL raw_done: data_ready seen=%0d writes=%0d want 1 1", seen, wr_cnt - snap);
    end
    tests++;
    if (!(wr_cyc < rd_start_cyc && rd_start_cyc >= cyc0) || wr_addr !== 4'd3 || rd_addr !== 4'd3) begin
      fails++;
      $display("FAIL raw_order: write cycle=%0d read cycle=%0d waddr=%0d raddr=%0d want write before read, both addr 3",
               wr_cyc, rd_start_cyc, wr_addr, rd_addr);
    end
    tick();
  endtask

  initial begin
    bus.in_req_address  = '0;
    bus.in_req_type     = '0;
    bus.in_req_matrix   = '0;
    bus.in_req_read_en  = '0;
    bus.in_req_write_en = '0;
    bus.in_req_data     = '0;
    test_reset();
    test_single_read();
    test_reset_mid_read();
    test_contention();
    test_write_posting();
    test_overflow();
    test_raw_order();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
